mips_pc_sequencer: RTL and testbench

//  PC register and run-control sequencer directly upstream of the single-cycle MiniMIPS core.
//  - Drives pc_new into the core and captures the core's pc_next each executed cycle.
//  - Gates execution through core_run. The top level ANDs reg_write and mem_write with core_run,
//    so no state changes while core_run=0.
//  - Provides run/stop/single-step control, a PC breakpoint, self-loop halt detection,
//    out-of-range PC fault, and cycle/retire counters.

---
 rtl/mips_pc_sequencer_if.sv | 9 +
 rtl/mips_pc_sequencer.sv | 149 ++++++++++++++
 tb/tb_mips_pc_sequencer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mips_pc_sequencer_if.sv
// rtl/mips_pc_sequencer_if.sv - PC/run handshake between the sequencer and the MiniMIPS core
interface mips_pc_sequencer_if;
  logic [31:0] pc_new;
  logic [31:0] pc_next;
  logic        core_run;

  modport master (output pc_new, output core_run, input pc_next);
  modport slave  (input pc_new, input core_run, output pc_next);
endinterface

// File: rtl/mips_pc_sequencer.sv
// rtl/mips_pc_sequencer.sv - PC register and run/stop/step/breakpoint sequencer for the MiniMIPS core
module mips_pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'd0,
  parameter int          IMEM_DEPTH = 256,
  parameter int          CNT_W      = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 step,
  input  logic                 clear,
  input  logic                 bp_en,
  input  logic [31:0]          bp_addr,
  mips_pc_sequencer_if.master  core,
  output logic [2:0]           state,
  output logic                 bp_flag,
  output logic [CNT_W-1:0]     cycle_cnt,
  output logic [CNT_W-1:0]     retired_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_STEP   = 3'd2,
    S_PAUSED = 3'd3,
    S_HALTED = 3'd4,
    S_FAULT  = 3'd5
  } state_e;

  localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_DEPTH);

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic               bp_flag_q, bp_flag_d;
  logic               bp_skip_q, bp_skip_d;
  logic [CNT_W-1:0]   cycle_q, cycle_d;
  logic [CNT_W-1:0]   retired_q, retired_d;

  logic bp_hit;
  logic core_run;
  logic exec_halt;
  logic exec_fault;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // bp_skip lets the trapped instruction retire once on resume instead of re-trapping
  assign bp_hit     = bp_en && (pc_q == bp_addr) && !bp_skip_q;
  assign core_run   = ((state_q == S_RUN) && !bp_hit) || (state_q == S_STEP);
  assign exec_halt  = core_run && (core.pc_next == pc_q);
  assign exec_fault = core_run && !exec_halt && (core.pc_next >= IMEM_LIMIT);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    bp_flag_d = bp_flag_q;
    bp_skip_d = bp_skip_q;
    cycle_d   = cycle_q;
    retired_d = retired_q;

    if (state_q == S_RUN || state_q == S_STEP) begin
      cycle_d = sat_inc(cycle_q);
    end

    if (core_run) begin
      retired_d = sat_inc(retired_q);
      if (exec_halt) begin
        state_d = S_HALTED;
      end else if (exec_fault) begin
        state_d = S_FAULT;
      end else begin
        pc_d      = core.pc_next;
        bp_skip_d = 1'b0;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (!stop) begin
          if (step)       state_d = S_STEP;
          else if (start) state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!exec_halt && !exec_fault) begin
          if (bp_hit) begin
            state_d   = S_PAUSED;
            bp_flag_d = 1'b1;
            bp_skip_d = 1'b1;
          end else if (stop) begin
            state_d = S_PAUSED;
          end
        end
      end
      S_STEP: begin
        if (!exec_halt && !exec_fault) state_d = S_PAUSED;
      end
      S_PAUSED: begin
        if (!stop) begin
          if (step) begin
            state_d   = S_STEP;
            bp_flag_d = 1'b0;
          end else if (start) begin
            state_d   = S_RUN;
            bp_flag_d = 1'b0;
          end
        end
      end
      default: ;
    endcase

    if (clear) begin
      state_d   = S_IDLE;
      pc_d      = RESET_PC;
      bp_flag_d = 1'b0;
      bp_skip_d = 1'b0;
      cycle_d   = '0;
      retired_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      bp_flag_q <= 1'b0;
      bp_skip_q <= 1'b0;
      cycle_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      bp_flag_q <= bp_flag_d;
      bp_skip_q <= bp_skip_d;
      cycle_q   <= cycle_d;
      retired_q <= retired_d;
    end
  end

  assign core.pc_new   = pc_q;
  assign core.core_run = core_run;
  assign state         = state_q;
  assign bp_flag       = bp_flag_q;
  assign cycle_cnt     = cycle_q;
  assign retired_cnt   = retired_q;

endmodule

// File: tb/tb_mips_pc_sequencer.sv
// tb/tb_mips_pc_sequencer.sv - scoreboard bench for mips_pc_sequencer with a small core model
module tb_mips_pc_sequencer;
  localparam int CNT_W      = 4;
  localparam int IMEM_DEPTH = 16;

  logic              clk = 1'b0;
  logic              rst_n, start, stop, step, clear, bp_en;
  logic [31:0]       bp_addr;
  logic [2:0]        state;
  logic              bp_flag;
  logic [CNT_W-1:0]  cycle_cnt, retired_cnt;

  logic [31:0] halt_at, fault_at, wrap_at;
  logic [31:0] exp_pc_q[$];
  logic [31:0] p;
  int n_checks = 0;
  int n_errors = 0;

  mips_pc_sequencer_if bus();

  mips_pc_sequencer #(
    .RESET_PC   (32'd0),
    .IMEM_DEPTH (IMEM_DEPTH),
    .CNT_W      (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .step        (step),
    .clear       (clear),
    .bp_en       (bp_en),
    .bp_addr     (bp_addr),
    .core        (bus.master),
    .state       (state),
    .bp_flag     (bp_flag),
    .cycle_cnt   (cycle_cnt),
    .retired_cnt (retired_cnt)
  );

  always #5 clk = ~clk;

  // Core model: sequential flow with programmable self-loop, out-of-range jump and loop-back
  always_comb begin
    if (bus.pc_new == halt_at)       bus.pc_next = bus.pc_new;
    else if (bus.pc_new == fault_at) bus.pc_next = 32'd20;
    else if (bus.pc_new == wrap_at)  bus.pc_next = 32'd0;
    else                             bus.pc_next = bus.pc_new + 32'd1;
  end

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) exp_pc_q.push_back(32'(i));
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.core_run === 1'b1) begin
      if (exp_pc_q.size() == 0) check("exec_extra", 32'd1, 32'd0);
      else                      check("exec_pc", bus.pc_new, exp_pc_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1; start = 1'b0; stop = 1'b0; step = 1'b0; clear = 1'b0;
    bp_en = 1'b0; bp_addr = 32'd0;
    halt_at = '1; fault_at = '1; wrap_at = '1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_pc", bus.pc_new, 32'd0);
    check("rst_state", 32'(state), 32'd0);
    check("rst_core_run", 32'(bus.core_run), 32'd0);
    check("rst_retired", 32'(retired_cnt), 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;

    // run 5 cycles then stop: sixth instruction still executes
    start = 1'b1; push_range(0, 5); tick(); start = 1'b0;
    repeat (5) tick();
    stop = 1'b1; tick(); stop = 1'b0;
    check("run_stop_state", 32'(state), 32'd3);
    check("run_stop_pc", bus.pc_new, 32'd6);
    check("run_stop_retired", 32'(retired_cnt), 32'd6);
    check("run_stop_cycles", 32'(cycle_cnt), 32'd6);

    // reset asynchronously in the middle of RUN at pc 9
    start = 1'b1; push_range(6, 8); tick(); start = 1'b0;
    repeat (3) tick();
    check("mid_run_pc", bus.pc_new, 32'd9);
    rst_n = 1'b0;
    #1;
    check("async_rst_pc", bus.pc_new, 32'd0);
    check("async_rst_state", 32'(state), 32'd0);
    check("async_rst_core_run", 32'(bus.core_run), 32'd0);
    check("async_rst_cycles", 32'(cycle_cnt), 32'd0);
    check("async_rst_retired", 32'(retired_cnt), 32'd0);
    #1 rst_n = 1'b1;

    // breakpoint at 3, resume executes it once without re-trapping
    bp_en = 1'b1; bp_addr = 32'd3;
    start = 1'b1; push_range(0, 2); tick(); start = 1'b0;
    repeat (3) tick();
    check("bp_core_run", 32'(bus.core_run), 32'd0);
    tick();
    check("bp_state", 32'(state), 32'd3);
    check("bp_flag_set", 32'(bp_flag), 32'd1);
    check("bp_pc", bus.pc_new, 32'd3);
    push_range(3, 4);
    start = 1'b1; tick(); start = 1'b0;
    check("bp_flag_clr", 32'(bp_flag), 32'd0);
    tick();
    check("bp_resume_pc", bus.pc_new, 32'd4);
    check("bp_resume_state", 32'(state), 32'd1);
    stop = 1'b1; tick(); stop = 1'b0;
    check("bp_cycles", 32'(cycle_cnt), 32'd6);
    check("bp_retired", 32'(retired_cnt), 32'd5);
    bp_en = 1'b0;

    // branch-to-self halts and is sticky until clear
    clear = 1'b1; tick(); clear = 1'b0;
    check("clr_pc", bus.pc_new, 32'd0);
    check("clr_retired", 32'(retired_cnt), 32'd0);
    halt_at = 32'd7;
    start = 1'b1; push_range(0, 7); tick(); start = 1'b0;
    repeat (8) tick();
    check("halt_state", 32'(state), 32'd4);
    check("halt_pc", bus.pc_new, 32'd7);
    check("halt_retired", 32'(retired_cnt), 32'd8);
    start = 1'b1; tick(); start = 1'b0;
    check("halt_sticky", 32'(state), 32'd4);
    check("halt_sticky_pc", bus.pc_new, 32'd7);
    clear = 1'b1; tick(); clear = 1'b0;
    check("halt_clr_state", 32'(state), 32'd0);
    check("halt_clr_pc", bus.pc_new, 32'd0);
    check("halt_clr_cycles", 32'(cycle_cnt), 32'd0);
    halt_at = '1;

    // jump past IMEM_DEPTH faults, keeps faulting PC
    fault_at = 32'd4;
    start = 1'b1; push_range(0, 4); tick(); start = 1'b0;
    repeat (5) tick();
    check("fault_state", 32'(state), 32'd5);
    check("fault_pc", bus.pc_new, 32'd4);
    check("fault_retired", 32'(retired_cnt), 32'd5);
    step = 1'b1; tick(); step = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    check("fault_sticky", 32'(state), 32'd5);
    check("fault_sticky_pc", bus.pc_new, 32'd4);
    clear = 1'b1; tick(); clear = 1'b0;
    fault_at = '1;

    // single step, then step+stop collision
    step = 1'b1; exp_pc_q.push_back(32'd0); tick(); step = 1'b0;
    check("step_state", 32'(state), 32'd2);
    check("step_core_run", 32'(bus.core_run), 32'd1);
    tick();
    check("step_done_state", 32'(state), 32'd3);
    check("step_done_pc", bus.pc_new, 32'd1);
    check("step_retired", 32'(retired_cnt), 32'd1);
    step = 1'b1; stop = 1'b1; tick(); step = 1'b0; stop = 1'b0;
    check("step_stop_state", 32'(state), 32'd3);
    check("step_stop_pc", bus.pc_new, 32'd1);
    check("step_stop_retired", 32'(retired_cnt), 32'd1);

    // long loop run saturates both counters
    wrap_at = 32'd7;
    start = 1'b1; tick(); start = 1'b0;
    p = 32'd1;
    repeat (20) begin
      exp_pc_q.push_back(p);
      p = (p == 32'd7) ? 32'd0 : p + 32'd1;
      tick();
    end
    stop = 1'b1; exp_pc_q.push_back(p);
    p = (p == 32'd7) ? 32'd0 : p + 32'd1;
    tick(); stop = 1'b0;
    check("sat_state", 32'(state), 32'd3);
    check("sat_pc", bus.pc_new, p);
    check("sat_retired", 32'(retired_cnt), 32'd15);
    check("sat_cycles", 32'(cycle_cnt), 32'd15);

    tick();
    check("exec_queue_empty", 32'(exp_pc_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
